// File: rtl/shift_chain_pkg.sv
// Shared types for the shift-chain reader: FSM encoding and counter width helper.
package shift_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    // Bits needed to hold values 0..max_val (never less than one).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/scan_stabilizer.sv
// Debounce helper: tracks the candidate word and how many consecutive scans matched it.
// Used by shift_chain_reader only when SHIFT_CHAIN_DEBOUNCE_EN is defined.
module scan_stabilizer
    import shift_chain_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEB_SCANS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic [WIDTH-1:0] word,
    output logic             accept_c
);
    localparam int unsigned CNT_W = cnt_width(DEB_SCANS);

    logic [WIDTH-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Saturating match count; a differing word restarts the run at one.
    always_comb begin
        cnt_next = cnt;
        if (word != cand) begin
            cnt_next = CNT_W'(1);
        end else if (cnt < CNT_W'(DEB_SCANS)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    assign accept_c = strobe && (cnt_next >= CNT_W'(DEB_SCANS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cand <= '0;
            cnt  <= '0;
        end else if (strobe) begin
            cand <= word;
            cnt  <= cnt_next;
        end
    end

endmodule

// File: rtl/shift_chain_reader.sv
// Scans a daisy chain of parallel-in/serial-out registers and presents the captured word.
// Define SHIFT_CHAIN_DEBOUNCE_EN to accept a word only after DEB_SCANS identical scans.
module shift_chain_reader
    import shift_chain_pkg::*;
#(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SCAN_GAP = 8
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
    ,
    parameter int unsigned DEB_SCANS = 3
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_en,
    input  logic             sr_data,
    output logic             sr_clk,
    output logic             sr_load,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             changed,
    output logic             busy
);
    localparam int unsigned GAP_LAST = (SCAN_GAP > 0) ? SCAN_GAP - 1 : 0;
    localparam int unsigned SLOT_MAX = 2 * CLK_DIV - 1;
    localparam int unsigned PH_MAX   = (SLOT_MAX > GAP_LAST) ? SLOT_MAX : GAP_LAST;
    localparam int unsigned PH_W     = cnt_width(PH_MAX);
    localparam int unsigned BIT_W    = cnt_width(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [BIT_W-1:0] bit_next;
    logic [WIDTH-1:0] shreg;
    logic             load_end;
    logic             slot_end;
    logic             gap_end;
    logic             sample;
    logic             capture;
    logic             take_c;
    logic             sr_clk_d;
    logic             sr_load_d;
    logic             busy_d;

    assign load_end = (phase == PH_W'(CLK_DIV - 1));
    assign slot_end = (phase == PH_W'(SLOT_MAX));
    assign gap_end  = (phase == PH_W'(GAP_LAST));
    assign sample   = (state == ST_SHIFT) && (phase == PH_W'(CLK_DIV - 1));
    assign capture  = (state == ST_SHIFT) && (state_next == ST_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (scan_en) state_next = ST_LOAD;
            ST_LOAD:  if (load_end) state_next = ST_SHIFT;
            ST_SHIFT: if (slot_end && (bit_cnt == '0)) state_next = ST_DONE;
            ST_DONE: begin
                if (SCAN_GAP != 0) state_next = ST_GAP;
                else               state_next = scan_en ? ST_LOAD : ST_IDLE;
            end
            ST_GAP:   if (gap_end) state_next = scan_en ? ST_LOAD : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Outputs decode the upcoming state so the registered pins line up with the state register.
    always_comb begin
        sr_clk_d  = 1'b0;
        sr_load_d = 1'b1;
        busy_d    = 1'b0;
        unique case (state_next)
            ST_LOAD: begin
                sr_load_d = 1'b0;
                busy_d    = 1'b1;
            end
            ST_SHIFT: begin
                sr_clk_d = (phase_next >= PH_W'(CLK_DIV));
                busy_d   = 1'b1;
            end
            ST_DONE: busy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_clk  <= 1'b0;
            sr_load <= 1'b1;
            busy    <= 1'b0;
        end else begin
            sr_clk  <= sr_clk_d;
            sr_load <= sr_load_d;
            busy    <= busy_d;
        end
    end

    // Phase restarts on every state change and at each bit-slot boundary.
    always_comb begin
        phase_next = phase + PH_W'(1);
        if ((state_next != state) || (state == ST_IDLE) || ((state == ST_SHIFT) && slot_end)) begin
            phase_next = '0;
        end
    end

    always_comb begin
        bit_next = bit_cnt;
        if (state == ST_LOAD) begin
            bit_next = BIT_W'(WIDTH - 1);
        end else if ((state == ST_SHIFT) && slot_end) begin
            bit_next = bit_cnt - BIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            phase   <= phase_next;
            bit_cnt <= bit_next;
            if (sample) begin
                shreg <= WIDTH'({shreg, sr_data});
            end
        end
    end

`ifdef SHIFT_CHAIN_DEBOUNCE_EN
    scan_stabilizer #(
        .WIDTH     (WIDTH),
        .DEB_SCANS (DEB_SCANS)
    ) u_stabilizer (
        .clk      (clk),
        .reset    (reset),
        .strobe   (capture),
        .word     (shreg),
        .accept_c (take_c)
    );
`else
    assign take_c = 1'b1;
`endif

    // Word handoff happens on entry to DONE so valid/changed are visible during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data    <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else begin
            valid   <= capture;
            changed <= capture && take_c && (shreg != data);
            if (capture && take_c) begin
                data <= shreg;
            end
        end
    end

endmodule

// File: tb/tb_shift_chain_reader.sv
// Scoreboard bench for shift_chain_reader: a 16-bit default instance and a 32-bit fast instance.
`timescale 1ns/1ps
module tb_shift_chain_reader;

    typedef struct packed {
        logic [31:0] word;
        logic        chg;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int nvalid_a = 0;

    logic        reset_a, scan_en_a, sr_data_a, sr_clk_a, sr_load_a, valid_a, changed_a, busy_a;
    logic [15:0] data_a;
    logic        reset_b, scan_en_b, sr_data_b, sr_clk_b, sr_load_b, valid_b, changed_b, busy_b;
    logic [31:0] data_b;

    shift_chain_reader #(
        .WIDTH(16), .CLK_DIV(2), .SCAN_GAP(8)
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
        , .DEB_SCANS(3)
`endif
    ) dut_a (
        .clk(clk), .reset(reset_a), .scan_en(scan_en_a), .sr_data(sr_data_a),
        .sr_clk(sr_clk_a), .sr_load(sr_load_a), .data(data_a), .valid(valid_a),
        .changed(changed_a), .busy(busy_a)
    );

    shift_chain_reader #(
        .WIDTH(32), .CLK_DIV(1), .SCAN_GAP(0)
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
        , .DEB_SCANS(3)
`endif
    ) dut_b (
        .clk(clk), .reset(reset_b), .scan_en(scan_en_b), .sr_data(sr_data_b),
        .sr_clk(sr_clk_b), .sr_load(sr_load_b), .data(data_b), .valid(valid_b),
        .changed(changed_b), .busy(busy_b)
    );

    // 74HC165-style chain models: parallel load while sr_load low, shift on sr_clk rise.
    logic [15:0] preset_a, chain_a;
    logic [31:0] preset_b, chain_b;
    logic        clk_q_a = 1'b0, clk_q_b = 1'b0;
    assign sr_data_a = chain_a[15];
    assign sr_data_b = chain_b[31];

    always @(posedge clk) begin
        if (!sr_load_a)                  chain_a <= preset_a;
        else if (sr_clk_a && !clk_q_a)   chain_a <= chain_a << 1;
        clk_q_a <= sr_clk_a;
        if (!sr_load_b)                  chain_b <= preset_b;
        else if (sr_clk_b && !clk_q_b)   chain_b <= chain_b << 1;
        clk_q_b <= sr_clk_b;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected-result model for instance A.
    logic [15:0] m_data = 16'h0;
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
    logic [15:0] m_cand = 16'h0;
    int          m_cnt  = 0;
`endif

    task automatic model_reset_a();
        m_data = 16'h0;
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
        m_cand = 16'h0;
        m_cnt  = 0;
`endif
    endtask

    task automatic exp_scan_a(input logic [15:0] w);
        exp_t e;
`ifdef SHIFT_CHAIN_DEBOUNCE_EN
        if (w == m_cand) begin
            if (m_cnt < 3) m_cnt++;
        end else begin
            m_cand = w;
            m_cnt  = 1;
        end
        e.chg = (m_cnt >= 3) && (w != m_data);
        if (m_cnt >= 3) m_data = w;
`else
        e.chg  = (w != m_data);
        m_data = w;
`endif
        e.word = {16'h0, m_data};
        q_a.push_back(e);
    endtask

    // Monitor: pops one expectation per valid pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (valid_a) begin
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_a_unexpected: valid with data %h, nothing expected", data_a);
            end else begin
                e = q_a.pop_front();
                check("sb_a_data", 32'(data_a), e.word);
                check("sb_a_changed", 32'(changed_a), 32'(e.chg));
            end
        end
        if (valid_b) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_b_unexpected: valid with data %h, nothing expected", data_b);
            end else begin
                e = q_b.pop_front();
                check("sb_b_data", data_b, e.word);
                check("sb_b_changed", 32'(changed_b), 32'(e.chg));
            end
        end
    end

    always @(posedge clk) if (valid_a) nvalid_a <= nvalid_a + 1;

    task automatic wait_valid(input int sel, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((sel == 0) ? valid_a : valid_b) && (n < budget));
        if (!((sel == 0) ? valid_a : valid_b)) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_%0d: no valid within %0d cycles", sel, budget);
        end
    endtask

    task automatic wait_load(input int sel, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel == 0) ? sr_load_a : sr_load_b) && (n < budget));
        if ((sel == 0) ? sr_load_a : sr_load_b) begin
            checks++;
            errors++;
            $display("FAIL wait_load_%0d: no load strobe within %0d cycles", sel, budget);
        end
    endtask

    task automatic count_rises(input int target, input int budget);
        int cnt = 0;
        int n   = 0;
        logic prev = 1'b0;
        while ((cnt < target) && (n < budget)) begin
            @(negedge clk);
            n++;
            if (sr_clk_a && !prev) cnt++;
            prev = sr_clk_a;
        end
        if (cnt < target) begin
            checks++;
            errors++;
            $display("FAIL count_rises: saw %0d of %0d sr_clk rises", cnt, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, n1, total, v0, b_scans;
        reset_a = 1'b0; scan_en_a = 1'b0; preset_a = 16'hA5C3;
        reset_b = 1'b0; scan_en_b = 1'b0; preset_b = 32'hDEADBEEF;
        #2 reset_a = 1'b1; reset_b = 1'b1;
        #1;
        check("rst_sr_clk", 32'(sr_clk_a), 0);
        check("rst_sr_load", 32'(sr_load_a), 1);
        check("rst_data", 32'(data_a), 0);
        check("rst_valid", 32'(valid_a), 0);
        check("rst_changed", 32'(changed_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        repeat (3) @(negedge clk);
        reset_a = 1'b0; reset_b = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_busy", 32'(busy_a), 0);
        check("idle_sr_load", 32'(sr_load_a), 1);

        // First scan latency, unchanged second scan, period.
        model_reset_a();
        exp_scan_a(16'hA5C3);
        exp_scan_a(16'hA5C3);
        scan_en_a = 1'b1;
        wait_valid(0, 200, n);
        check("latency_a", n, 67);
        wait_valid(0, 200, n);
        check("period_a", n, 75);

        // scan_en dropped at bit 5: scan completes, then idle.
        exp_scan_a(16'hA5C3);
        wait_load(0, 100, n);
        count_rises(10, 200);
        scan_en_a = 1'b0;
        v0 = nvalid_a;
        repeat (150) @(negedge clk);
        check("single_valid", 32'(nvalid_a - v0), 1);
        check("stop_sr_load", 32'(sr_load_a), 1);
        check("stop_sr_clk", 32'(sr_clk_a), 0);
        check("stop_busy", 32'(busy_a), 0);
        check("stop_queue", 32'(q_a.size()), 0);

        // Reset mid-SHIFT, then a fresh scan of 16'h0001.
        scan_en_a = 1'b1;
        wait_load(0, 100, n);
        count_rises(6, 200);
        #2 reset_a = 1'b1;
        #1;
        check("midrst_sr_clk", 32'(sr_clk_a), 0);
        check("midrst_sr_load", 32'(sr_load_a), 1);
        check("midrst_data", 32'(data_a), 0);
        check("midrst_busy", 32'(busy_a), 0);
        check("midrst_valid", 32'(valid_a), 0);
        model_reset_a();
        preset_a = 16'h0001;
        @(negedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        exp_scan_a(16'h0001);
        wait_valid(0, 200, n);
        check("latency_after_rst", n, 67);
        scan_en_a = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_scan_queue", 32'(q_a.size()), 0);
        check("rst_scan_busy", 32'(busy_a), 0);

`ifdef SHIFT_CHAIN_DEBOUNCE_EN
        // Debounce: 00FF, then three 00FE scans; only the last one is accepted.
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        preset_a = 16'h00FF;
        q_a.push_back('{word: 32'h0000, chg: 1'b0});
        q_a.push_back('{word: 32'h0000, chg: 1'b0});
        q_a.push_back('{word: 32'h0000, chg: 1'b0});
        q_a.push_back('{word: 32'h00FE, chg: 1'b1});
        scan_en_a = 1'b1;
        wait_valid(0, 200, n);
        preset_a = 16'h00FE;
        repeat (3) wait_valid(0, 200, n);
        scan_en_a = 1'b0;
        repeat (20) @(negedge clk);
        check("deb_queue", 32'(q_a.size()), 0);
        check("deb_data", 32'(data_a), 32'h00FE);
        b_scans = 3;
        q_b.push_back('{word: 32'h0, chg: 1'b0});
        q_b.push_back('{word: 32'h0, chg: 1'b0});
        q_b.push_back('{word: 32'hDEADBEEF, chg: 1'b1});
`else
        b_scans = 2;
        q_b.push_back('{word: 32'hDEADBEEF, chg: 1'b1});
        q_b.push_back('{word: 32'hDEADBEEF, chg: 1'b0});
`endif

        // Fast 32-bit instance: sr_clk toggles every cycle, 66-cycle period.
        scan_en_b = 1'b1;
        wait_valid(1, 200, n);
        check("latency_b", n, 66);
        for (int k = 1; k < b_scans; k++) begin
            wait_load(1, 100, n1);
            total = n1;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                total++;
                if (k == 1) check("b_sr_clk_toggle", 32'(sr_clk_b), 32'(i % 2));
            end
            wait_valid(1, 200, n);
            check("period_b", total + n, 66);
        end
        scan_en_b = 1'b0;
        @(negedge clk);
        check("b_idle_busy", 32'(busy_b), 0);
        check("b_idle_sr_load", 32'(sr_load_b), 1);
        check("b_queue", 32'(q_b.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
